// File: rtl/lc3_operand_fetch_pkg.sv
// lc3_operand_fetch_pkg
//   Shared constants for the LC-3 operand-fetch slice: ALU opcodes,
//   instruction field positions and a small opcode classifier.
//   No ports.
package lc3_operand_fetch_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;

   // Low bit of each register field in the instruction word.
   localparam int DR_LSB  = 9;
   localparam int SR1_LSB = 6;
   localparam int SR2_LSB = 0;
   localparam int IMM_BIT = 5;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
   endfunction

   // ADD/AND have the imm5 / SR2 operand-b forms; NOT does not.
   function automatic logic has_src2_form(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/lc3_operand_fetch_regfile.sv
// lc3_operand_fetch_regfile
//   NREG x DATA_W general register file: two combinational read ports and
//   one write port, with write-through bypass (a read of the register being
//   written this cycle returns the write data). Async reset clears storage.
// Ports
//   clk, rst              clock, async active-high reset
//   i_we/i_waddr/i_wdata  write port
//   i_raddr1/o_rdata1     read port 1
//   i_raddr2/o_rdata2     read port 2
module lc3_operand_fetch_regfile #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr1,
   output logic [DATA_W-1:0] o_rdata1,
   input  logic [AW-1:0]     i_raddr2,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] r_mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
   assign o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/lc3_operand_fetch.sv
// lc3_operand_fetch
//   Stage in front of the LC-3 ALU. Decodes ADD/AND/NOT, reads operands from
//   the register file (with write-back bypass), sign-extends imm5, tracks a
//   per-register busy scoreboard and presents a registered result to the ALU.
// Ports
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready/in_instr     instruction input handshake
//   out_valid/out_ready            ALU output handshake
//   out_a/out_b/out_opcode/out_dr  ALU operands, opcode, destination
//   wb_en/wb_dr/wb_data            register write-back port
//   busy                           scoreboard, bit i = write to Ri outstanding
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready never looks at in_valid. out_* hold steady while
// out_valid && !out_ready.
module lc3_operand_fetch
   import lc3_operand_fetch_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [3:0]        out_opcode,
   output logic [AW-1:0]     out_dr,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_dr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [NREG-1:0]   busy
);

   logic [3:0]        w_opcode;
   logic [AW-1:0]     w_dr, w_sr1, w_sr2;
   logic              w_is_alu, w_use_sr2, w_hazard, w_accept, w_issue;
   logic              w_haz_sr1, w_haz_sr2, w_haz_dr;
   logic [DATA_W-1:0] w_rdata1, w_rdata2, w_b;
   logic [NREG-1:0]   w_busy_nxt;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_a, r_out_b;
   logic [3:0]        r_out_opcode;
   logic [AW-1:0]     r_out_dr;
   logic [NREG-1:0]   r_busy;

   assign w_opcode  = in_instr[15:12];
   assign w_dr      = in_instr[DR_LSB +: AW];
   assign w_sr1     = in_instr[SR1_LSB +: AW];
   assign w_sr2     = in_instr[SR2_LSB +: AW];
   assign w_is_alu  = is_alu_op(w_opcode);
   assign w_use_sr2 = has_src2_form(w_opcode) && !in_instr[IMM_BIT];

   lc3_operand_fetch_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_en),
      .i_waddr  (wb_dr),
      .i_wdata  (wb_data),
      .i_raddr1 (w_sr1),
      .o_rdata1 (w_rdata1),
      .i_raddr2 (w_sr2),
      .o_rdata2 (w_rdata2)
   );

   always_comb begin
      w_b = '0;
      if (has_src2_form(w_opcode)) begin
         w_b = in_instr[IMM_BIT] ? {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]} : w_rdata2;
      end
   end

   // A write-back landing this cycle on a busy register resolves its hazard;
   // the bypassed read already carries the new value.
   assign w_haz_sr1 = r_busy[w_sr1] && !(wb_en && (wb_dr == w_sr1));
   assign w_haz_sr2 = r_busy[w_sr2] && !(wb_en && (wb_dr == w_sr2));
   assign w_haz_dr  = r_busy[w_dr]  && !(wb_en && (wb_dr == w_dr));

   // Unsupported opcodes are simply drained, so they never stall.
   assign w_hazard = w_is_alu && (w_haz_sr1 || (w_use_sr2 && w_haz_sr2) || w_haz_dr);

   assign in_ready = !rst && (!r_out_valid || out_ready) && !w_hazard;
   assign w_accept = in_valid && in_ready;
   assign w_issue  = w_accept && w_is_alu;

   // Clear before set: an issue to the register being written back stays busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_en)   w_busy_nxt[wb_dr] = 1'b0;
      if (w_issue) w_busy_nxt[w_dr]  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_a      <= '0;
         r_out_b      <= '0;
         r_out_opcode <= '0;
         r_out_dr     <= '0;
         r_busy       <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_issue) begin
            r_out_valid  <= 1'b1;
            r_out_a      <= w_rdata1;
            r_out_b      <= w_b;
            r_out_opcode <= w_opcode;
            r_out_dr     <= w_dr;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_a      = r_out_a;
   assign out_b      = r_out_b;
   assign out_opcode = r_out_opcode;
   assign out_dr     = r_out_dr;
   assign busy       = r_busy;

endmodule
